data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Multi-channel global data memory behind data_controller; serves its mem2read_*/mem2write_* ports.
//  One channel per thread lane (MAX_THREADS). Each channel runs one request at a time, with a fixed, parameterised latency.
//  Shared storage array. Testbench preload port initialises it before kernel launch.
// PARAMETERS
//  MAX_THREADS     4   number of channels (thread lanes)
//  MEM_ADDR_WIDTH  8   word address width; depth = 2**MEM_ADDR_WIDTH
//  MEM_DATA_WIDTH  16  word width
//  READ_LATENCY    2   cycles from read accept to resp_val (>=1)
//  WRITE_LATENCY   2   cycles from write accept to write_resp_val (>=1)
// PORTS
//  clk                     in   1                      clock, rising edge
//  reset                   in   1                      asynchronous, active-low reset
//  mem2read_req_rdy        out  1 [MAX_THREADS]        channel can accept a read
//  mem2read_req_addr       in   MEM_ADDR_WIDTH [MAX_THREADS]  read address
//  mem2read_req_addr_val   in   1 [MAX_THREADS]        read request valid
//  mem2read_resp_rdy       in   1 [MAX_THREADS]        requester can take read data
//  mem2read_resp_data      out  MEM_DATA_WIDTH [MAX_THREADS]  read data
//  mem2read_resp_data_val  out  1 [MAX_THREADS]        read data valid
//  mem2write_req_rdy       out  1 [MAX_THREADS]        channel can accept a write
//  mem2write_req_addr      in   MEM_ADDR_WIDTH [MAX_THREADS]  write address
//  mem2write_req_data      in   MEM_DATA_WIDTH [MAX_THREADS]  write data
//  mem2write_req_val       in   1 [MAX_THREADS]        write request valid
//  mem2write_resp_val      out  1 [MAX_THREADS]        write complete
//  init_we                 in   1                      TB preload write enable
//  init_addr               in   MEM_ADDR_WIDTH         TB preload address
//  init_data               in   MEM_DATA_WIDTH         TB preload data
// BEHAVIOUR
//  Reset (reset=0, async): all channels go to IDLE. Outputs: req_rdy=1, resp_val=0, resp_data=0, write_resp_val=0.
//   The storage array is NOT cleared.
//  Per-channel FSM: IDLE -> BUSY -> RESP -> DRAIN -> IDLE.
//  IDLE:
//   - req_rdy = (state==IDLE), for both read and write.
//   - Read wins if addr_val and write val are both high. The write stays pending.
//   - On accept, latch the op and address. Read: sample mem[addr] at the accept edge. Write: commit mem[addr]=data at the accept edge.
//   - Load the counter with the op's LATENCY-1, then go to BUSY.
//  BUSY: decrement the counter each cycle. At 0, go to RESP.
//   - Read: resp_data_val=1, resp_data=sampled word.
//   - Write: write_resp_val=1.
//   - With LATENCY=L, resp is first visible L cycles after the accept edge.
//  RESP (read): hold data and val stable until resp_rdy=1. On that edge, drop val, zero the data, go to DRAIN.
//  RESP (write): hold write_resp_val=1 until write_req_val=0. Then drop it and go to IDLE.
//  DRAIN (read only): wait for addr_val=0, then go to IDLE.
//   - This prevents re-accepting a request the controller holds through writeback.
//   - resp_rdy=1 and addr_val=0 on the same edge: go straight from RESP to IDLE.
//  Same-edge hazards on the array:
//   - Read accepted on the edge where another channel commits a write to the same address: the read returns the OLD value.
//   - Several writes to one address on one edge: highest channel index wins.
//   - init_we wins over all channel writes on that edge.
//  Reset mid-operation: in-flight reads are dropped. Writes already committed stay in the array.
//  Addresses wrap naturally; there is no out-of-range detection.
// STRUCTURE
//  Package data_mem_pkg:
//   - channel state enum: IDLE=2'd0, BUSY=2'd1, RESP=2'd2, DRAIN=2'd3
//   - op encoding: OP_RD=1'b0, OP_WR=1'b1
//   - counter width function clog2(max(READ_LATENCY,WRITE_LATENCY))
//  Sub-module data_mem_channel: one FSM, counter, latched op/addr/data, and the handshake outputs.
//   - Instantiated MAX_THREADS times with a generate loop.
//  Top level: array, write-arbitration loop (index ascending, last assignment wins), per-channel read sampling.
// TESTING
//  1. Preload mem[0x10]=0x1234. Ch0 read 0x10, resp_rdy=1 -> resp_val rises 2 cycles after accept with data 0x1234. rdy stays low until addr_val drops.
//  2. All 4 channels write addr 0x20..0x23 = 0xA0..0xA3 together.
//     -> 4 write_resp_val pulses 2 cycles later, held until val drops.
//     -> read back returns 0xA0..0xA3.
//  3. Ch1 and ch2 write 0x30 on the same edge (0x1111 / 0x2222) -> a later read of 0x30 = 0x2222.
//  4. Ch0 reads 0x40 (old 0x0005) on the same edge ch3 writes 0x40=0x0009 -> ch0 gets 0x0005; a later read gets 0x0009.
//  5. Read with resp_rdy low for 5 cycles -> data/val stable throughout; handshake completes on the rdy edge. Then addr_val held 3 more cycles -> no second accept.
//  6. Assert reset=0 while ch0 is in BUSY -> all outputs return to reset values asynchronously. After release, ch0 accepts a new read normally.

Source files
------------

// File: rtl/data_mem_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_pkg
// Purpose : Shared types and helpers for the multi-channel data memory.
//   - ch_state_t : per-channel FSM state encoding
//   - OP_RD/OP_WR: latched operation encoding
//   - cnt_width(): latency counter width for the larger of the two latencies
// ----------------------------------------------------------------------------
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } ch_state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // The counter is loaded with LATENCY-1, so clog2(max latency) bits suffice.
    // A latency of 1 would give zero bits, so keep at least one.
    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int m;
        int w;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_mem_channel.sv
// ----------------------------------------------------------------------------
// data_mem_channel
// Purpose : One thread-lane channel of the data memory. Runs one request at a
//           time through IDLE -> BUSY -> RESP -> DRAIN -> IDLE.
// Ports   :
//   clk, rst_n          clock, async active-low reset
//   i_rd_val/i_rd_word  read request valid, memory word at the read address
//   i_rd_resp_rdy       requester can take read data
//   i_wr_val            write request valid
//   o_req_rdy           channel idle (read and write ready)
//   o_rd_data(_val)     registered read response
//   o_wr_resp_val       registered write completion
//   o_wr_commit         write accepted this cycle (top commits it to the array)
//   o_state             FSM state, for observation
// Handshake: a request is accepted on a rising edge where o_req_rdy and its
//   valid are both high. Read responses complete on an edge where
//   o_rd_data_val and i_rd_resp_rdy are both high; write responses complete
//   on the first edge where i_wr_val is low.
// ----------------------------------------------------------------------------
module data_mem_channel
    import data_mem_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = 16,
    parameter int READ_LATENCY   = 2,
    parameter int WRITE_LATENCY  = 2,
    parameter int CW             = cnt_width(READ_LATENCY, WRITE_LATENCY)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_rd_val,
    input  logic [MEM_DATA_WIDTH-1:0] i_rd_word,
    input  logic                      i_rd_resp_rdy,
    input  logic                      i_wr_val,
    output logic                      o_req_rdy,
    output logic [MEM_DATA_WIDTH-1:0] o_rd_data,
    output logic                      o_rd_data_val,
    output logic                      o_wr_resp_val,
    output logic                      o_wr_commit,
    output logic [1:0]                o_state
);

    ch_state_t               r_state;
    logic                    r_op;
    logic [CW-1:0]           r_cnt;
    logic [MEM_DATA_WIDTH-1:0] r_word;
    logic [MEM_DATA_WIDTH-1:0] r_rd_data;
    logic                    r_rd_val;
    logic                    r_wr_resp;

    // The address only matters on the accept edge (sample or commit), so it
    // is not kept beyond that edge.
    assign o_req_rdy     = (r_state == IDLE);
    assign o_wr_commit   = (r_state == IDLE) && i_wr_val && !i_rd_val;
    assign o_rd_data     = r_rd_data;
    assign o_rd_data_val = r_rd_val;
    assign o_wr_resp_val = r_wr_resp;
    assign o_state       = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= OP_RD;
            r_cnt     <= '0;
            r_word    <= '0;
            r_rd_data <= '0;
            r_rd_val  <= 1'b0;
            r_wr_resp <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Read wins; a simultaneous write stays pending.
                    if (i_rd_val) begin
                        r_op    <= OP_RD;
                        r_word  <= i_rd_word;
                        r_cnt   <= CW'(READ_LATENCY - 1);
                        r_state <= BUSY;
                    end else if (i_wr_val) begin
                        r_op    <= OP_WR;
                        r_cnt   <= CW'(WRITE_LATENCY - 1);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        if (r_op == OP_RD) begin
                            r_rd_val  <= 1'b1;
                            r_rd_data <= r_word;
                        end else begin
                            r_wr_resp <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (r_op == OP_RD) begin
                        if (i_rd_resp_rdy) begin
                            r_rd_val  <= 1'b0;
                            r_rd_data <= '0;
                            // Skip DRAIN when the request is already withdrawn.
                            r_state   <= i_rd_val ? DRAIN : IDLE;
                        end
                    end else if (!i_wr_val) begin
                        r_wr_resp <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                DRAIN: begin
                    // Avoid re-accepting a read the controller still holds.
                    if (!i_rd_val) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// Purpose : Multi-channel global data memory. One channel per thread lane,
//           shared storage array, preload port for initialisation.
// Ports   :
//   clk, reset                      clock, async active-low reset
//   mem2read_req_*/mem2read_resp_*  per-channel read request/response
//   mem2write_req_*/mem2write_resp_val per-channel write request/completion
//   init_we/init_addr/init_data     preload write (wins over channel writes)
//   o_dbg_state                     per-channel FSM state
// The array is not reset. Same-address same-edge writes: highest channel wins,
// preload beats all. Reads sample before same-edge writes land (old value).
// ----------------------------------------------------------------------------
module data_memory
    import data_mem_pkg::*;
#(
    parameter int MAX_THREADS    = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16,
    parameter int READ_LATENCY   = 2,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    output logic [MAX_THREADS-1:0]                        mem2read_req_rdy,
    input  logic [MAX_THREADS-1:0][MEM_ADDR_WIDTH-1:0]    mem2read_req_addr,
    input  logic [MAX_THREADS-1:0]                        mem2read_req_addr_val,
    input  logic [MAX_THREADS-1:0]                        mem2read_resp_rdy,
    output logic [MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0]    mem2read_resp_data,
    output logic [MAX_THREADS-1:0]                        mem2read_resp_data_val,
    output logic [MAX_THREADS-1:0]                        mem2write_req_rdy,
    input  logic [MAX_THREADS-1:0][MEM_ADDR_WIDTH-1:0]    mem2write_req_addr,
    input  logic [MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0]    mem2write_req_data,
    input  logic [MAX_THREADS-1:0]                        mem2write_req_val,
    output logic [MAX_THREADS-1:0]                        mem2write_resp_val,
    input  logic                                          init_we,
    input  logic [MEM_ADDR_WIDTH-1:0]                     init_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                     init_data,
    output logic [MAX_THREADS-1:0][1:0]                   o_dbg_state
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    logic [MEM_DATA_WIDTH-1:0]                 r_mem [DEPTH];
    logic [MAX_THREADS-1:0][MEM_DATA_WIDTH-1:0] w_rd_word;
    logic [MAX_THREADS-1:0]                    w_wr_commit;
    logic [MAX_THREADS-1:0]                    w_req_rdy;

    assign mem2read_req_rdy  = w_req_rdy;
    assign mem2write_req_rdy = w_req_rdy;

    for (genvar g = 0; g < MAX_THREADS; g++) begin : g_ch
        assign w_rd_word[g] = r_mem[mem2read_req_addr[g]];

        data_mem_channel #(
            .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
            .READ_LATENCY   (READ_LATENCY),
            .WRITE_LATENCY  (WRITE_LATENCY)
        ) u_ch (
            .clk           (clk),
            .rst_n         (reset),
            .i_rd_val      (mem2read_req_addr_val[g]),
            .i_rd_word     (w_rd_word[g]),
            .i_rd_resp_rdy (mem2read_resp_rdy[g]),
            .i_wr_val      (mem2write_req_val[g]),
            .o_req_rdy     (w_req_rdy[g]),
            .o_rd_data     (mem2read_resp_data[g]),
            .o_rd_data_val (mem2read_resp_data_val[g]),
            .o_wr_resp_val (mem2write_resp_val[g]),
            .o_wr_commit   (w_wr_commit[g]),
            .o_state       (o_dbg_state[g])
        );
    end

    // Ascending loop: the last (highest) channel's assignment wins; preload
    // is assigned after the loop so it beats every channel. Commits are
    // blocked while reset is asserted since channels sit in IDLE then.
    always_ff @(posedge clk) begin
        for (int c = 0; c < MAX_THREADS; c++) begin
            if (w_wr_commit[c] && reset)
                r_mem[mem2write_req_addr[c]] <= mem2write_req_data[c];
        end
        if (init_we) r_mem[init_addr] <= init_data;
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;

  logic clk;
  logic reset;
  logic [3:0]       rd_rdy, rd_val, resp_rdy, resp_val;
  logic [3:0]       wr_rdy, wr_val, wr_resp;
  logic [3:0][7:0]  rd_addr, wr_addr;
  logic [3:0][15:0] resp_data, wr_data;
  logic [3:0][1:0]  dbg_state;
  logic             init_we;
  logic [7:0]       init_addr;
  logic [15:0]      init_data;

  logic [17:0] exp_q[$];
  int n_total;
  int n_bad;

  data_memory dut (
    .clk                    (clk),
    .reset                  (reset),
    .mem2read_req_rdy       (rd_rdy),
    .mem2read_req_addr      (rd_addr),
    .mem2read_req_addr_val  (rd_val),
    .mem2read_resp_rdy      (resp_rdy),
    .mem2read_resp_data     (resp_data),
    .mem2read_resp_data_val (resp_val),
    .mem2write_req_rdy      (wr_rdy),
    .mem2write_req_addr     (wr_addr),
    .mem2write_req_data     (wr_data),
    .mem2write_req_val      (wr_val),
    .mem2write_resp_val     (wr_resp),
    .init_we                (init_we),
    .init_addr              (init_addr),
    .init_data              (init_data),
    .o_dbg_state            (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // scoreboard: pop on each read handshake (sampled mid-cycle)
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (resp_val[c] && resp_rdy[c]) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(c), 32'hFFFF);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("sb_ch", 32'(c), 32'(e[17:16]));
          chk("sb_data", 32'(resp_data[c]), 32'(e[15:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic do_read(input int ch, input logic [7:0] a, input logic [15:0] d);
    int cycles;
    rd_addr[ch] = a;
    resp_rdy[ch] = 1'b1;
    exp_q.push_back({2'(ch), d});
    rd_val[ch] = 1'b1;
    @(posedge clk); #1;
    chk("rd_rdy_busy", 32'(rd_rdy[ch]), 0);
    cycles = 0;
    while (!resp_val[ch] && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("rd_lat", 32'(cycles), RD_LAT);
    @(posedge clk); #1;
    chk("rd_val_drop", 32'(resp_val[ch]), 0);
    chk("rd_data_zero", 32'(resp_data[ch]), 0);
    chk("rd_drain_rdy", 32'(rd_rdy[ch]), 0);
    rd_val[ch] = 1'b0;
    @(posedge clk); #1;
    chk("rd_idle_rdy", 32'(rd_rdy[ch]), 1);
  endtask

  task automatic do_write(input logic [3:0] mask);
    int cycles;
    wr_val = mask;
    @(posedge clk); #1;
    chk("wr_rdy_busy", 32'(wr_rdy & mask), 0);
    cycles = 0;
    while ((wr_resp & mask) != mask && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("wr_lat", 32'(cycles), WR_LAT);
    repeat (2) @(posedge clk);
    #1;
    chk("wr_hold", 32'(wr_resp & mask), 32'(mask));
    wr_val = 4'b0;
    @(posedge clk); #1;
    chk("wr_drop", 32'(wr_resp & mask), 0);
    chk("wr_idle", 32'(wr_rdy & mask), 32'(mask));
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;
    reset = 1'b0;
    rd_val = '0; resp_rdy = '0; wr_val = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    n_total = 0; n_bad = 0;

    #3;
    chk("rst_rd_rdy", 32'(rd_rdy), 32'hF);
    chk("rst_wr_rdy", 32'(wr_rdy), 32'hF);
    chk("rst_resp_val", 32'(resp_val), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_wr_resp", 32'(wr_resp), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // basic read of preloaded word
    preload(8'h10, 16'h1234);
    do_read(0, 8'h10, 16'h1234);

    // all four channels write together, then read back
    for (int c = 0; c < 4; c++) begin
      wr_addr[c] = 8'(8'h20 + c);
      wr_data[c] = 16'(16'hA0 + c);
    end
    do_write(4'hF);
    for (int c = 0; c < 4; c++) do_read(c, 8'(8'h20 + c), 16'(16'hA0 + c));

    // same-address same-edge writes: higher channel wins
    wr_addr[1] = 8'h30; wr_data[1] = 16'h1111;
    wr_addr[2] = 8'h30; wr_data[2] = 16'h2222;
    do_write(4'b0110);
    do_read(0, 8'h30, 16'h2222);

    // read and write to one address on the same edge: read sees old value
    preload(8'h40, 16'h0005);
    rd_addr[0] = 8'h40; resp_rdy[0] = 1'b1;
    wr_addr[3] = 8'h40; wr_data[3] = 16'h0009;
    exp_q.push_back({2'd0, 16'h0005});
    rd_val[0] = 1'b1; wr_val[3] = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (!(resp_val[0] && wr_resp[3]) && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("hz_resp", 32'({resp_val[0], wr_resp[3]}), 32'b11);
    @(posedge clk); #1;
    rd_val[0] = 1'b0; wr_val[3] = 1'b0;
    @(posedge clk); #1;
    chk("hz_idle", 32'({rd_rdy[0], wr_rdy[3]}), 32'b11);
    do_read(1, 8'h40, 16'h0009);

    // read wins over write on one channel; write stays pending
    rd_addr[1] = 8'h10; resp_rdy[1] = 1'b1;
    wr_addr[1] = 8'h50; wr_data[1] = 16'hBEEF;
    exp_q.push_back({2'd1, 16'h1234});
    rd_val[1] = 1'b1; wr_val[1] = 1'b1;
    @(posedge clk); #1;
    chk("rw_state", 32'(dbg_state[1]), 1);
    cycles = 0;
    while (!resp_val[1] && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("rw_wr_quiet", 32'(wr_resp[1]), 0);
    @(posedge clk); #1;
    rd_val[1] = 1'b0;
    @(posedge clk); #1;
    chk("rw_pending_rdy", 32'(wr_rdy[1]), 1);
    cycles = 0;
    while (!wr_resp[1] && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("rw_wr_resp", 32'(wr_resp[1]), 1);
    wr_val[1] = 1'b0;
    @(posedge clk); #1;
    do_read(2, 8'h50, 16'hBEEF);

    // back-pressure: resp_rdy low for 5 cycles, then addr_val held 3 more
    rd_addr[2] = 8'h10; resp_rdy[2] = 1'b0;
    exp_q.push_back({2'd2, 16'h1234});
    rd_val[2] = 1'b1;
    cycles = 0;
    while (!resp_val[2] && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_val", 32'(resp_val[2]), 1);
      chk("stall_data", 32'(resp_data[2]), 32'h1234);
      @(posedge clk); #1;
    end
    resp_rdy[2] = 1'b1;
    @(posedge clk); #1;
    chk("stall_drop", 32'(resp_val[2]), 0);
    chk("stall_zero", 32'(resp_data[2]), 0);
    for (int i = 0; i < 3; i++) begin
      chk("drain_no_accept", 32'({rd_rdy[2], resp_val[2], dbg_state[2]}), 32'b0_0_11);
      @(posedge clk); #1;
    end
    rd_val[2] = 1'b0;
    @(posedge clk); #1;
    chk("drain_exit", 32'(rd_rdy[2]), 1);

    // async reset while channel 0 is busy
    rd_addr[0] = 8'h10; resp_rdy[0] = 1'b1;
    rd_val[0] = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(dbg_state[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_rdy", 32'({rd_rdy, wr_rdy}), 32'hFF);
    chk("arst_val", 32'({resp_val, wr_resp}), 0);
    chk("arst_data", 32'(resp_data), 0);
    rd_val[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_read(0, 8'h10, 16'h1234);
    do_read(1, 8'h20, 16'h00A0);

    // random write/read pairs across different channels
    for (int i = 0; i < 6; i++) begin
      int ch, oc;
      logic [7:0] a;
      logic [15:0] d;
      ch = int'($urandom_range(0, 3));
      oc = (ch + int'($urandom_range(1, 3))) % 4;
      a = 8'($urandom_range(128, 255));
      d = 16'($urandom_range(0, 65535));
      wr_addr[ch] = a; wr_data[ch] = d;
      do_write(4'(1 << ch));
      do_read(oc, a, d);
    end

    repeat (2) @(posedge clk);
    chk("sb_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
